// File: rtl/crc_frame_serializer.sv
// Frames parallel words into a bit-serial stream for serial_crc and reports the masked CRC per frame.
// Optional frame abort (s_abort/frm_abort) is enabled by defining CRC_SER_ABORT_EN.
module crc_frame_serializer #(
    parameter int DATA_W = 32,
    parameter int BITS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [1:0]        s_mode,
    input  logic [31:0]       s_poly,
    output logic              crc_init,
    output logic              crc_data,
    output logic              crc_valid,
    output logic [1:0]        crc_mode,
    output logic [31:0]       crc_poly,
    input  logic [31:0]       crc_result,
    output logic              frm_done,
    output logic [31:0]       frm_crc,
    output logic [BITS_W-1:0] frm_bits,
    output logic              busy
`ifdef CRC_SER_ABORT_EN
    ,
    input  logic              s_abort,
    output logic              frm_abort
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [BITS_W-1:0] BITS_ONE = BITS_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_last;
    logic                r_first;
    logic [CNT_W-1:0]    r_cnt;
    logic [BITS_W-1:0]   r_bits;
    logic [1:0]          r_mode;
    logic [31:0]         r_poly;
    logic [31:0]         r_frm_crc;
    logic [BITS_W-1:0]   r_frm_bits;
    logic                w_accept;
    logic                w_word_end;
    logic                w_abort;

    function automatic logic [31:0] f_mask(input logic [1:0] m);
        case (m)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    assign w_accept   = s_valid && (r_state == ST_IDLE);
    assign w_word_end = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

`ifdef CRC_SER_ABORT_EN
    logic r_frm_abort;
    assign w_abort   = s_abort && (r_state != ST_IDLE);
    assign frm_abort = r_frm_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frm_abort <= 1'b0;
        end else begin
            r_frm_abort <= w_abort;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = r_first ? ST_INIT : ST_SHIFT;
            ST_INIT:  w_next = ST_SHIFT;
            ST_SHIFT: if (w_word_end) w_next = r_last ? ST_WAIT : ST_IDLE;
            ST_WAIT:  w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        // Abort wins over every other transition, including the move into DONE.
        if (w_abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_last     <= 1'b0;
            r_first    <= 1'b1;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_mode     <= 2'b00;
            r_poly     <= 32'h0;
            r_frm_crc  <= 32'h0;
            r_frm_bits <= '0;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                r_first <= 1'b1;
            end else begin
                if (w_accept) begin
                    r_shreg <= s_data;
                    r_last  <= s_last;
                    r_cnt   <= '0;
                    if (r_first) begin
                        r_mode  <= s_mode;
                        r_poly  <= s_poly;
                        r_bits  <= '0;
                        r_first <= 1'b0;
                    end
                end
                if (r_state == ST_SHIFT) begin
                    r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNT_ONE;
                    if (r_bits != '1) r_bits <= r_bits + BITS_ONE;
                end
                // serial_crc has absorbed the final bit by the end of WAIT.
                if (r_state == ST_WAIT) begin
                    r_frm_crc  <= crc_result & f_mask(r_mode);
                    r_frm_bits <= r_bits;
                    r_first    <= 1'b1;
                end
            end
        end
    end

    assign s_ready   = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign crc_init  = (r_state == ST_INIT);
    assign crc_valid = (r_state == ST_SHIFT);
    assign crc_data  = (r_state == ST_SHIFT) && r_shreg[DATA_W-1];
    assign crc_mode  = r_mode;
    assign crc_poly  = r_poly;
    assign frm_done  = (r_state == ST_DONE);
    assign frm_crc   = r_frm_crc;
    assign frm_bits  = r_frm_bits;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Scoreboard bench for crc_frame_serializer with a behavioural serial_crc attached to its CRC port.
module tb_crc_frame_serializer;
    localparam int DATA_W = 32;
    localparam int BITS_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [1:0]        s_mode = 2'b00;
    logic [31:0]       s_poly = 32'h0;
    logic              crc_init, crc_data, crc_valid;
    logic [1:0]        crc_mode;
    logic [31:0]       crc_poly;
    logic [31:0]       crc_result;
    logic              frm_done;
    logic [31:0]       frm_crc;
    logic [BITS_W-1:0] frm_bits;
    logic              busy;
`ifdef CRC_SER_ABORT_EN
    logic              s_abort = 1'b0;
    logic              frm_abort;
`endif

    crc_frame_serializer #(.DATA_W(DATA_W), .BITS_W(BITS_W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .s_mode(s_mode), .s_poly(s_poly),
        .crc_init(crc_init), .crc_data(crc_data), .crc_valid(crc_valid),
        .crc_mode(crc_mode), .crc_poly(crc_poly), .crc_result(crc_result),
        .frm_done(frm_done), .frm_crc(frm_crc), .frm_bits(frm_bits), .busy(busy)
`ifdef CRC_SER_ABORT_EN
        , .s_abort(s_abort), .frm_abort(frm_abort)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [1:0] m);
        case (m)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b,
                                            input logic [1:0] m, input logic [31:0] p);
        int   w;
        logic fb;
        w  = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
        fb = c[w-1] ^ b;
        return ((c << 1) ^ (fb ? p : 32'h0)) & mask_of(m);
    endfunction

    // Behavioural serial_crc; upper bits carry junk so the block's masking is exercised.
    logic [31:0] m_crc;
    logic        force_en = 1'b0;
    logic [31:0] force_val = 32'h0;
    always @(posedge clk or posedge rst) begin
        if (rst)            m_crc <= 32'h0;
        else if (crc_init)  m_crc <= 32'h0;
        else if (crc_valid) m_crc <= crc_bit(m_crc, crc_data, crc_mode, crc_poly);
    end
    assign crc_result = force_en ? force_val : (m_crc | (32'hA5A5_A5A5 & ~mask_of(crc_mode)));

    typedef struct {
        logic [31:0]       crc;
        logic [BITS_W-1:0] bits;
        int                lat;
    } frame_t;

    frame_t exp_frames[$];
    logic   exp_bits[$];
    int     done_cnt = 0;
    int     bits_seen = 0;
    int     init_cnt = 0;

    // Monitor: pops expected bits on crc_valid and expected frames on frm_done.
    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                init_cnt  = 0;
                bits_seen = 0;
            end else begin
                if (crc_init) init_cnt++;
                if (crc_valid) begin
                    bits_seen++;
                    chk("s_ready_during_shift", {31'b0, s_ready}, 32'h0);
                    if (exp_bits.size() == 0) begin
                        chk("unexpected_bit", 32'h1, 32'h0);
                    end else begin
                        chk("crc_data", {31'b0, crc_data}, {31'b0, exp_bits.pop_front()});
                    end
                end
                if (frm_done) begin
                    if (exp_frames.size() == 0) begin
                        chk("unexpected_done", 32'h1, 32'h0);
                    end else begin
                        f = exp_frames.pop_front();
                        chk("frm_crc", frm_crc, f.crc);
                        chk("frm_bits", {{(32-BITS_W){1'b0}}, frm_bits}, {{(32-BITS_W){1'b0}}, f.bits});
                        chk("init_pulses", init_cnt, 32'd1);
                        if (f.lat >= 0) chk("done_latency", cyc, f.lat);
                    end
                    init_cnt  = 0;
                    bits_seen = 0;
                    done_cnt++;
                end
            end
        end
    end

    logic        in_frame = 1'b0;
    logic [31:0] run_crc;
    int          run_bits;
    logic [1:0]  cur_mode;
    logic [31:0] cur_poly;
    int          acc_cyc;
    int          n_words;

    // Caller is positioned just after a falling edge; returns one falling edge after the accept.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] m,
                             input logic [31:0] p, input logic hold);
        int     n;
        frame_t f;
        n = 0;
        if (!in_frame) begin
            cur_mode = m; cur_poly = p; run_crc = 32'h0; run_bits = 0; n_words = 0;
        end
        s_valid = 1'b1; s_data = d; s_last = last; s_mode = m; s_poly = p;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'b0, n >= 300}, 32'h0);
        if (n_words == 0) acc_cyc = cyc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            exp_bits.push_back(d[i]);
            run_crc = crc_bit(run_crc, d[i], cur_mode, cur_poly);
        end
        run_bits += DATA_W;
        n_words++;
        in_frame = !last;
        if (last) begin
            f.crc  = (force_en ? force_val : run_crc) & mask_of(cur_mode);
            f.bits = (run_bits >= (1 << BITS_W) - 1) ? '1 : BITS_W'(run_bits);
            f.lat  = (n_words == 1) ? acc_cyc + DATA_W + 3 : -1;
            exp_frames.push_back(f);
        end
        @(negedge clk);
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n, target;
        n = 0;
        target = done_cnt + 1;
        while (done_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'b0, n >= 500}, 32'h0);
        @(negedge clk);
    endtask

    task automatic wait_bits(input int k);
        int n;
        n = 0;
        while (bits_seen < k && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bits_timeout", {31'b0, n >= 200}, 32'h0);
    endtask

    logic [31:0] saved_crc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'b0, s_ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_crc_init", {31'b0, crc_init}, 32'h0);
        chk("rst_crc_valid", {31'b0, crc_valid}, 32'h0);
        chk("rst_frm_done", {31'b0, frm_done}, 32'h0);
        chk("rst_frm_crc", frm_crc, 32'h0);
        chk("rst_crc_poly", crc_poly, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // CRC8, single word: bits 0001 0010 ..., done 35 cycles after accept.
        send_word(32'h1234_5678, 1'b1, 2'b00, 32'h07, 1'b0);
        wait_frame();
        chk("crc8_upper_zero", {8'h0, frm_crc[31:8]}, 32'h0);
        chk("crc8_low_byte", {24'h0, frm_crc[7:0]}, {24'h0, crc_result[7:0]});
        $display("T1 crc8 frame: frm_crc=%h frm_bits=%0d", frm_crc, frm_bits);

        // CRC32, two-word frame.
        send_word(32'h1122_3344, 1'b0, 2'b10, 32'h04C1_1DB7, 1'b0);
        send_word(32'h5566_7788, 1'b1, 2'b10, 32'h04C1_1DB7, 1'b0);
        wait_frame();
        $display("T2 crc32 frame: frm_crc=%h frm_bits=%0d", frm_crc, frm_bits);

        // CRC16 with forced crc_result: mask keeps only the low half.
        force_en = 1'b1; force_val = 32'hFFFF_1234;
        send_word(32'hAABB_CCDD, 1'b1, 2'b01, 32'h8005, 1'b0);
        wait_frame();
        chk("crc16_forced", frm_crc, 32'h0000_1234);
        force_en = 1'b0;
        chk("mode_hold", {30'b0, crc_mode}, 32'h1);
        chk("poly_hold", crc_poly, 32'h8005);
        $display("T3 crc16 forced: frm_crc=%h", frm_crc);

        // s_valid held through SHIFT; second word carries a different mode/poly.
        send_word(32'hCAFE_BABE, 1'b0, 2'b00, 32'h31, 1'b1);
        send_word(32'h0F0F_00FF, 1'b1, 2'b11, 32'h1EDC_6F41, 1'b0);
        wait_frame();
        chk("hold_mode", {30'b0, crc_mode}, 32'h0);
        chk("hold_poly", crc_poly, 32'h31);
        saved_crc = frm_crc;
        repeat (5) @(negedge clk);
        chk("frm_crc_hold", frm_crc, saved_crc);
        $display("T4 held valid: frm_crc=%h frm_bits=%0d", frm_crc, frm_bits);

        // Reset at bit 10 of SHIFT.
        send_word(32'h1357_9BDF, 1'b1, 2'b10, 32'h04C1_1DB7, 1'b0);
        wait_bits(10);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_crc_valid", {31'b0, crc_valid}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_s_ready", {31'b0, s_ready}, 32'h1);
        chk("midrst_crc_poly", crc_poly, 32'h0);
        chk("midrst_frm_crc", frm_crc, 32'h0);
        exp_bits.delete(); exp_frames.delete(); in_frame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'h2468_ACE0, 1'b1, 2'b00, 32'h07, 1'b0);
        wait_frame();
        $display("T5 after reset: frm_crc=%h frm_bits=%0d", frm_crc, frm_bits);

`ifdef CRC_SER_ABORT_EN
        saved_crc = frm_crc;
        send_word(32'h8421_1248, 1'b1, 2'b01, 32'h1021, 1'b0);
        wait_bits(5);
        #1;
        s_abort = 1'b1;
        exp_bits.delete(); exp_frames.delete(); in_frame = 1'b0;
        @(negedge clk);
        s_abort = 1'b0;
        chk("abort_pulse", {31'b0, frm_abort}, 32'h1);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        init_cnt = 0; bits_seen = 0;
        @(negedge clk);
        chk("abort_pulse_end", {31'b0, frm_abort}, 32'h0);
        repeat (40) @(negedge clk);
        chk("abort_frm_crc_kept", frm_crc, saved_crc);
        send_word(32'h0000_00FF, 1'b1, 2'b00, 32'h07, 1'b0);
        wait_frame();
        $display("T6 abort: frm_crc=%h", frm_crc);
`endif

        chk("bits_queue_empty", exp_bits.size(), 32'h0);
        chk("frame_queue_empty", exp_frames.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
